cordic_sched: RTL and testbench

CORDIC_SCHED -- requirements
Module: cordic_sched

---
 rtl/cordic_sched.sv | 108 ++++++++++
 tb/tb_cordic_sched.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_sched.sv
// cordic_sched: round-robin scheduler that time-shares one pipelined CORDIC among NCHAN
// channels, tagging each issue so results come back with their channel number.
module cordic_sched #(
  parameter int NCHAN = 4,
  parameter int WIDTH = 16,
  parameter int LAT   = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [NCHAN-1:0]       req,
  input  logic [NCHAN*WIDTH-1:0] i_in,
  input  logic [NCHAN*WIDTH-1:0] q_in,
  input  logic [NCHAN*WIDTH-1:0] phase_in,
  output logic [WIDTH-1:0]       cordic_xi,
  output logic [WIDTH-1:0]       cordic_yi,
  output logic [WIDTH-1:0]       cordic_zi,
  input  logic [WIDTH-1:0]       cordic_xo,
  input  logic [WIDTH-1:0]       cordic_yo,
  output logic                   out_valid,
  output logic [2:0]             out_chan,
  output logic [WIDTH-1:0]       out_i,
  output logic [WIDTH-1:0]       out_q,
  output logic [NCHAN-1:0]       overrun
);
  logic [NCHAN-1:0] pending;
  logic [NCHAN-1:0] gnt_mask;
  logic [7:0]       pend_x;
  logic [2:0]       last_grant;
  logic [2:0]       gnt;
  logic             gnt_any;
  logic [3:0]       cand;
  logic [WIDTH-1:0] hold_i [8];
  logic [WIDTH-1:0] hold_q [8];
  logic [WIDTH-1:0] hold_p [8];
  logic [LAT:0]     tag_v;
  logic [2:0]       tag_c [LAT+1];

  assign pend_x = 8'(pending);

  // Scan downwards so the last hit is the nearest channel after last_grant.
  always_comb begin
    gnt_any = 1'b0;
    gnt = last_grant;
    cand = '0;
    for (int j = NCHAN; j >= 1; j--) begin
      cand = 4'(last_grant) + 4'(j);
      cand = (cand >= 4'(NCHAN)) ? cand - 4'(NCHAN) : cand;
      if (pend_x[cand[2:0]]) begin
        gnt_any = 1'b1;
        gnt = cand[2:0];
      end
    end
  end

  assign gnt_mask = gnt_any ? {{(NCHAN-1){1'b0}}, 1'b1} << gnt : '0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pending <= '0;
      overrun <= '0;
      last_grant <= 3'(NCHAN-1);
      tag_v <= '0;
      for (int k = 0; k <= LAT; k++) tag_c[k] <= '0;
      for (int k = 0; k < 8; k++) begin
        hold_i[k] <= '0;
        hold_q[k] <= '0;
        hold_p[k] <= '0;
      end
      cordic_xi <= '0;
      cordic_yi <= '0;
      cordic_zi <= '0;
      out_valid <= 1'b0;
      out_chan <= '0;
      out_i <= '0;
      out_q <= '0;
    end else if (!enable) begin
      pending <= '0;
      overrun <= '0;
      tag_v <= '0;
      out_valid <= 1'b0;
    end else begin
      if (gnt_any) begin
        cordic_xi <= hold_i[gnt];
        cordic_yi <= hold_q[gnt];
        cordic_zi <= hold_p[gnt];
        last_grant <= gnt;
      end
      tag_v <= {tag_v[LAT-1:0], gnt_any};
      tag_c[0] <= gnt;
      for (int k = 1; k <= LAT; k++) tag_c[k] <= tag_c[k-1];
      out_valid <= tag_v[LAT];
      out_chan <= tag_c[LAT];
      out_i <= cordic_xo;
      out_q <= cordic_yo;
      // A request on a channel being granted this edge refills its slot without loss.
      pending <= (pending & ~gnt_mask) | req;
      overrun <= overrun | (req & pending & ~gnt_mask);
      for (int k = 0; k < NCHAN; k++) begin
        if (req[k]) begin
          hold_i[k] <= i_in[k*WIDTH +: WIDTH];
          hold_q[k] <= q_in[k*WIDTH +: WIDTH];
          hold_p[k] <= phase_in[k*WIDTH +: WIDTH];
        end
      end
    end
  end
endmodule

// File: tb/tb_cordic_sched.sv
// tb_cordic_sched: directed and random checks of cordic_sched against a queue-based model
// of round-robin issue, fixed-latency return and sticky overrun.
module tb_cordic_sched;
  localparam int NCHAN = 4;
  localparam int WIDTH = 16;
  localparam int LAT   = 16;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic enable = 1'b1;
  logic [NCHAN-1:0] req = '0;
  logic [NCHAN*WIDTH-1:0] i_in = '0, q_in = '0, phase_in = '0;
  logic [WIDTH-1:0] cordic_xi, cordic_yi, cordic_zi, cordic_xo, cordic_yo;
  logic out_valid;
  logic [2:0] out_chan;
  logic [WIDTH-1:0] out_i, out_q;
  logic [NCHAN-1:0] overrun;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clock = ~clock;

  cordic_sched #(.NCHAN(NCHAN), .WIDTH(WIDTH), .LAT(LAT)) dut (
    .clock(clock), .reset(reset), .enable(enable), .req(req),
    .i_in(i_in), .q_in(q_in), .phase_in(phase_in),
    .cordic_xi(cordic_xi), .cordic_yi(cordic_yi), .cordic_zi(cordic_zi),
    .cordic_xo(cordic_xo), .cordic_yo(cordic_yo),
    .out_valid(out_valid), .out_chan(out_chan), .out_i(out_i), .out_q(out_q),
    .overrun(overrun)
  );

  // Stand-in CORDIC: LAT-stage pipe computing xo = xi ^ zi, yo = yi + zi.
  logic [WIDTH-1:0] px [LAT];
  logic [WIDTH-1:0] py [LAT];
  always @(posedge clock) begin
    px[0] <= cordic_xi ^ cordic_zi;
    py[0] <= cordic_yi + cordic_zi;
    for (int s = 1; s < LAT; s++) begin
      px[s] <= px[s-1];
      py[s] <= py[s-1];
    end
  end
  assign cordic_xo = px[LAT-1];
  assign cordic_yo = py[LAT-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Behavioural model: pending/hold per channel, expected results queued with due edge.
  typedef struct {int chan; logic [WIDTH-1:0] xo; logic [WIDTH-1:0] yo; int due;} exp_t;
  exp_t exp_list[$];
  exp_t e;
  logic [WIDTH-1:0] m_i [NCHAN];
  logic [WIDTH-1:0] m_q [NCHAN];
  logic [WIDTH-1:0] m_p [NCHAN];
  logic [NCHAN-1:0] m_pend, m_ovr;
  int m_last, m_g, n;
  logic e_valid = 1'b0, e_iss = 1'b0;
  int e_chan;
  logic [WIDTH-1:0] e_i, e_q, e_xi, e_yi, e_zi;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_pend = '0; m_ovr = '0; m_last = NCHAN-1; n = 0;
      exp_list.delete(); e_valid = 1'b0; e_iss = 1'b0;
    end else begin
      n++;
      e_valid = 1'b0;
      e_iss = 1'b0;
      if (!enable) begin
        m_pend = '0; m_ovr = '0; exp_list.delete();
      end else begin
        if (exp_list.size() > 0 && exp_list[0].due == n) begin
          e = exp_list.pop_front();
          e_valid = 1'b1; e_chan = e.chan; e_i = e.xo; e_q = e.yo;
        end
        m_g = -1;
        for (int j = 1; j <= NCHAN; j++)
          if (m_g < 0 && m_pend[(m_last + j) % NCHAN]) m_g = (m_last + j) % NCHAN;
        if (m_g >= 0) begin
          e.chan = m_g; e.xo = m_i[m_g] ^ m_p[m_g]; e.yo = m_q[m_g] + m_p[m_g];
          e.due = n + LAT + 1;
          exp_list.push_back(e);
          e_iss = 1'b1; e_xi = m_i[m_g]; e_yi = m_q[m_g]; e_zi = m_p[m_g];
          m_pend[m_g] = 1'b0;
          m_last = m_g;
        end
        for (int k = 0; k < NCHAN; k++) begin
          if (req[k]) begin
            if (m_pend[k]) m_ovr[k] = 1'b1;
            m_pend[k] = 1'b1;
            m_i[k] = i_in[k*WIDTH +: WIDTH];
            m_q[k] = q_in[k*WIDTH +: WIDTH];
            m_p[k] = phase_in[k*WIDTH +: WIDTH];
          end
        end
      end
    end
  end

  int res_c[$];
  int res_t[$];
  logic [WIDTH-1:0] res_i[$];

  always @(negedge clock) begin
    cyc++;
    if (reset) begin
      chk("out_valid", 32'(out_valid), 32'(e_valid));
      if (e_valid) begin
        chk("out_chan", 32'(out_chan), 32'(e_chan));
        chk("out_i", 32'(out_i), 32'(e_i));
        chk("out_q", 32'(out_q), 32'(e_q));
      end
      chk("overrun", 32'(overrun), 32'(m_ovr));
      if (e_iss) begin
        chk("cordic_xi", 32'(cordic_xi), 32'(e_xi));
        chk("cordic_yi", 32'(cordic_yi), 32'(e_yi));
        chk("cordic_zi", 32'(cordic_zi), 32'(e_zi));
      end
      if (out_valid) begin
        res_c.push_back(int'(out_chan));
        res_t.push_back(cyc);
        res_i.push_back(out_i);
      end
    end
  end

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic drain();
    repeat (LAT + 8) tick();
  endtask

  task automatic clr();
    res_c.delete(); res_t.delete(); res_i.delete();
  endtask

  task automatic do_reset();
    reset = 1'b0; tick(); reset = 1'b1; tick();
  endtask

  task automatic set_ch(input int k, input logic [WIDTH-1:0] i, input logic [WIDTH-1:0] q,
                        input logic [WIDTH-1:0] p);
    i_in[k*WIDTH +: WIDTH] = i;
    q_in[k*WIDTH +: WIDTH] = q;
    phase_in[k*WIDTH +: WIDTH] = p;
  endtask

  int cnt [NCHAN];
  int bad;

  initial begin
    repeat (3) tick();
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_chan", 32'(out_chan), 0);
    chk("rst_out_i", 32'(out_i), 0);
    chk("rst_xi", 32'(cordic_xi), 0);
    chk("rst_ovr", 32'(overrun), 0);
    reset = 1'b1;
    tick();

    // Single uncontested request, literal expectations.
    set_ch(2, 16'h1234, 16'h0F0F, 16'h4000);
    req = 4'b0100; tick(); req = '0;
    tick();
    chk("single_xi", 32'(cordic_xi), 32'h1234);
    chk("single_zi", 32'(cordic_zi), 32'h4000);
    repeat (LAT) tick();
    chk("single_early", 32'(out_valid), 0);
    tick();
    chk("single_valid", 32'(out_valid), 1);
    chk("single_chan", 32'(out_chan), 2);
    chk("single_i", 32'(out_i), 32'h5234);
    chk("single_q", 32'(out_q), 32'h4F0F);
    drain();

    // All-channel burst right after reset.
    do_reset(); clr();
    for (int k = 0; k < NCHAN; k++) set_ch(k, 16'(16'h1100 * (k + 1)), 16'(k), 16'h0);
    req = 4'hF; tick(); req = '0;
    drain();
    chk("burst_n", res_c.size(), 4);
    if (res_c.size() == 4) begin
      for (int k = 0; k < 4; k++) chk("burst_order", res_c[k], k);
      chk("burst_back2back", res_t[3] - res_t[0], 3);
    end
    chk("burst_ovr", 32'(overrun), 0);

    // Overrun: channel 0 wins while channel 1 is re-requested.
    clr();
    set_ch(0, 16'hA000, 16'h0001, 16'h0000);
    set_ch(1, 16'hA111, 16'h0002, 16'h0000);
    req = 4'b0011; tick();
    set_ch(1, 16'hBBBB, 16'h0003, 16'h0000);
    req = 4'b0010; tick(); req = '0;
    chk("ovr_flag", 32'(overrun), 32'b0010);
    drain();
    chk("ovr_n", res_c.size(), 2);
    if (res_c.size() == 2) begin
      chk("ovr_first", res_c[0], 0);
      chk("ovr_second", res_c[1], 1);
      chk("ovr_value", 32'(res_i[1]), 32'hBBBB);
    end

    // Fairness under continuous requests.
    clr();
    repeat (64) begin
      for (int k = 0; k < NCHAN; k++) set_ch(k, 16'($urandom), 16'($urandom), 16'($urandom));
      req = 4'hF; tick();
    end
    req = '0;
    drain();
    chk("fair_n", 32'(res_c.size() >= 64), 1);
    if (res_c.size() >= 64) begin
      for (int k = 0; k < NCHAN; k++) cnt[k] = 0;
      bad = 0;
      for (int i = 0; i < 64; i++) cnt[res_c[i]]++;
      for (int i = 0; i + 3 < 64; i++)
        for (int a = i; a < i + 4; a++)
          for (int b = a + 1; b < i + 4; b++)
            if (res_c[a] == res_c[b]) bad++;
      for (int k = 0; k < NCHAN; k++) chk("fair_count", cnt[k], 16);
      chk("fair_window", bad, 0);
    end

    // Flush with three tags in flight and an overrun pending.
    do_reset(); clr();
    req = 4'b0011; tick();
    req = 4'b0011; tick();
    req = 4'b0100; tick();
    req = '0; tick();
    chk("flush_pre_ovr", 32'(overrun), 32'b0010);
    enable = 1'b0; tick(); enable = 1'b1;
    chk("flush_ovr", 32'(overrun), 0);
    clr(); drain();
    chk("flush_quiet", res_c.size(), 0);
    set_ch(3, 16'h3333, 16'h0444, 16'h0005);
    req = 4'b1000; tick(); req = '0;
    drain();
    chk("flush_after_n", res_c.size(), 1);
    if (res_c.size() == 1) chk("flush_after_chan", res_c[0], 3);

    // Asynchronous reset pulsed between edges mid-burst.
    clr();
    req = 4'hF; tick(); req = '0; tick(); tick();
    #1 reset = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 0);
    chk("arst_chan", 32'(out_chan), 0);
    chk("arst_i", 32'(out_i), 0);
    chk("arst_q", 32'(out_q), 0);
    chk("arst_xi", 32'(cordic_xi), 0);
    chk("arst_yi", 32'(cordic_yi), 0);
    chk("arst_zi", 32'(cordic_zi), 0);
    chk("arst_ovr", 32'(overrun), 0);
    #1 reset = 1'b1;
    tick(); clr(); drain();
    chk("arst_quiet", res_c.size(), 0);
    req = 4'b0010; tick(); req = '0;
    drain();
    chk("arst_after_n", res_c.size(), 1);
    if (res_c.size() == 1) chk("arst_after_chan", res_c[0], 1);

    // Random traffic with occasional flushes.
    repeat (600) begin
      for (int k = 0; k < NCHAN; k++) set_ch(k, 16'($urandom), 16'($urandom), 16'($urandom));
      req = 4'($urandom & $urandom);
      enable = ($urandom_range(0, 39) != 0);
      tick();
    end
    req = '0; enable = 1'b1;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
